// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with a valid/ready handshake.
// SKID=1 adds a second entry so that in_ready is registered and the stage
// keeps full throughput under backpressure. SKID=0 is a single register
// whose in_ready is combinational from out_ready.
// The control field is held at zero whenever the main entry is invalid,
// so a bubble never carries live write enables downstream.
module pipe_stage_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Main entry drives the outputs; skid entry holds the overflow entry.
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

  logic accept;
  logic drain;

  // Ready is suppressed while reset is held so no handshake can complete.
  generate
    if (SKID) begin : g_skid_ready
      assign in_ready = !rst && !skid_valid_q;
    end else begin : g_comb_ready
      assign in_ready = !rst && (out_ready || !main_valid_q);
    end
  endgenerate

  assign accept = in_valid && in_ready;
  assign drain  = main_valid_q && out_ready;

  // Next-state selection: flush wins, then fill, refill, overflow or drain.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      // Payload bits may stay stale; only valid and ctrl are cleared.
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end
    end else if (skid_valid_q) begin
      // Full: in_ready is low, so the only move is skid -> main on drain.
      if (drain) begin
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end
    end else if (accept && drain) begin
      main_data_d = in_data;
      main_ctrl_d = in_ctrl;
    end else if (SKID && accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_ctrl_d  = in_ctrl;
    end else if (drain) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
    end
  end

  // State registers with asynchronous clear of every held entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule
